instr_fetch: RTL and testbench

- Instruction-fetch stage directly upstream of the decode/breakdown stage.
- Owns the PC and issues requests to instruction memory over a req/ready handshake.
- Presents `instr` and its `pcReadData` downstream, and applies the `pcOp`/`pcWriteData` redirect that decode returns.
- Holds one-deep sequential prefetch (PC+4) to hide memory latency; prefetch is discarded on redirect.

---
 rtl/instr_fetch.sv | 139 +++++++++++++
 tb/tb_instr_fetch.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: PC owner and instruction fetch with one-deep sequential prefetch
module instr_fetch #(
  parameter int AddrWidth = 32,
  parameter int InstrWidth = 32,
  parameter logic [AddrWidth-1:0] ResetPc = '0,
  parameter logic [InstrWidth-1:0] NopInstr = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            pcOp,
  input  logic [AddrWidth-1:0]  pcWriteData,
  output logic                  imemReq,
  output logic [AddrWidth-1:0]  imemAddr,
  input  logic                  imemReady,
  input  logic [InstrWidth-1:0] imemRdata,
  output logic [InstrWidth-1:0] instr,
  output logic [AddrWidth-1:0]  pcReadData,
  output logic                  instrValid
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_VALID, S_DROP} state_t;

  state_t                r_state, w_state_n;
  logic                  r_req, w_req_n;
  logic [AddrWidth-1:0]  r_addr, w_addr_n;
  logic [AddrWidth-1:0]  r_pc, w_pc_n;
  logic [InstrWidth-1:0] r_instr, w_instr_n;
  logic [AddrWidth-1:0]  r_pc_rd, w_pc_rd_n;
  logic                  r_pf_full, w_pf_full_n;
  logic [InstrWidth-1:0] r_pf_instr, w_pf_instr_n;
  logic [AddrWidth-1:0]  r_pf_addr, w_pf_addr_n;

  // A response only counts while our own request is up; stray readies are ignored.
  logic                 w_rdy;
  logic [AddrWidth-1:0] w_next;
  logic [AddrWidth-1:0] w_tgt;
  assign w_rdy  = r_req && imemReady;
  assign w_next = r_pc_rd + AddrWidth'(4);
  assign w_tgt  = pcWriteData & ~AddrWidth'(3);

  assign imemReq    = r_req;
  assign imemAddr   = r_addr;
  assign instrValid = (r_state == S_VALID);
  assign instr      = instrValid ? r_instr : NopInstr;
  assign pcReadData = r_pc_rd;

  // State register and all datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_addr     <= ResetPc;
      r_pc       <= ResetPc;
      r_instr    <= NopInstr;
      r_pc_rd    <= ResetPc;
      r_pf_full  <= 1'b0;
      r_pf_instr <= NopInstr;
      r_pf_addr  <= ResetPc;
    end else begin
      r_state    <= w_state_n;
      r_req      <= w_req_n;
      r_addr     <= w_addr_n;
      r_pc       <= w_pc_n;
      r_instr    <= w_instr_n;
      r_pc_rd    <= w_pc_rd_n;
      r_pf_full  <= w_pf_full_n;
      r_pf_instr <= w_pf_instr_n;
      r_pf_addr  <= w_pf_addr_n;
    end
  end

  // Next-state: demand fetch, prefetch into the buffer, pcOp handling and stale-response drop.
  always_comb begin
    w_state_n    = r_state;
    w_req_n      = r_req;
    w_addr_n     = r_addr;
    w_pc_n       = r_pc;
    w_instr_n    = r_instr;
    w_pc_rd_n    = r_pc_rd;
    w_pf_full_n  = r_pf_full;
    w_pf_instr_n = r_pf_instr;
    w_pf_addr_n  = r_pf_addr;
    case (r_state)
      S_IDLE: begin
        w_req_n   = 1'b1;
        w_addr_n  = r_pc;
        w_state_n = S_WAIT;
      end
      S_WAIT: begin
        if (w_rdy) begin
          w_instr_n = imemRdata;
          w_pc_rd_n = r_addr;
          w_req_n   = 1'b0;
          w_state_n = S_VALID;
        end
      end
      S_DROP: begin
        if (w_rdy) begin
          w_addr_n  = r_pc;
          w_state_n = S_WAIT;
        end
      end
      default: begin
        if (pcOp == 3'b001) begin
          if (w_rdy) begin
            w_pf_full_n  = 1'b1;
            w_pf_instr_n = imemRdata;
            w_pf_addr_n  = r_addr;
            w_req_n      = 1'b0;
          end else if (!r_pf_full && !r_req) begin
            w_req_n  = 1'b1;
            w_addr_n = w_next;
          end
        end else if (pcOp == 3'b010) begin
          w_pf_full_n = 1'b0;
          w_pc_n      = w_tgt;
          w_state_n   = (r_req && !w_rdy) ? S_DROP : S_WAIT;
          if (!r_req || w_rdy) begin
            w_req_n  = 1'b1;
            w_addr_n = w_tgt;
          end
        end else if (r_pf_full) begin
          w_instr_n   = r_pf_instr;
          w_pc_rd_n   = r_pf_addr;
          w_pf_full_n = 1'b0;
        end else if (w_rdy) begin
          w_instr_n = imemRdata;
          w_pc_rd_n = r_addr;
          w_req_n   = 1'b0;
        end else begin
          w_state_n = S_WAIT;
          if (!r_req) begin
            w_req_n  = 1'b1;
            w_addr_n = w_next;
          end
        end
      end
    endcase
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench for instr_fetch with a latency-programmable memory model
module tb_instr_fetch;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0, reset = 1'b0, force_rdy = 1'b0, fresh = 1'b0;
  logic [2:0] pcOp = 3'b000;
  logic [31:0] pcWriteData = '0;
  logic imemReq, imemReady, instrValid;
  logic [31:0] imemAddr, imemRdata, instr, pcReadData;

  int errors = 0, checks = 0, lat = 2, cnt = 0, cyc = 0;
  int consume_cyc = 0, pop_cyc = 0, log_at_consume = 0;
  logic prev_req = 1'b0, prev_rdy = 1'b0;
  logic [31:0] prev_addr = '0, m_pc = '0;
  logic [31:0] exp_q[$], req_log[$], wd_q[$];
  logic [2:0] op_q[$];

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk(clk), .reset(reset), .pcOp(pcOp), .pcWriteData(pcWriteData),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemReady(imemReady), .imemRdata(imemRdata),
    .instr(instr), .pcReadData(pcReadData), .instrValid(instrValid)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a * 32'd7 + 32'h0050_0093;
  endfunction

  assign imemReady = (imemReq && cnt >= lat) || force_rdy;
  assign imemRdata = force_rdy ? 32'hDEAD_BEEF : mem(imemAddr);
  always @(posedge clk) cnt <= (imemReq && !imemReady) ? cnt + 1 : 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor and pcOp driver: pops the scoreboard on each newly presented instruction.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      if (prev_req && !prev_rdy) begin
        check("req_held", 32'(imemReq), 32'd1);
        check("addr_stable", imemAddr, prev_addr);
      end else if (imemReq) req_log.push_back(imemAddr);
      if (!instrValid) begin
        check("nop_when_invalid", instr, NOP);
        pcOp = 3'b010;
        pcWriteData = 32'h0000_0BAD;
      end else begin
        if (fresh) begin
          check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) m_pc = exp_q.pop_front();
          fresh = 1'b0;
          pop_cyc = cyc;
        end
        check("pcReadData", pcReadData, m_pc);
        check("instr", instr, mem(m_pc));
        if (op_q.size() != 0) begin
          pcOp = op_q.pop_front();
          pcWriteData = wd_q.pop_front();
        end else pcOp = 3'b001;
        if (pcOp != 3'b001) begin
          exp_q.push_back(pcOp == 3'b010 ? (pcWriteData & 32'hFFFF_FFFC) : m_pc + 32'd4);
          fresh = 1'b1;
          consume_cyc = cyc;
          log_at_consume = req_log.size();
        end
      end
    end
    prev_req = imemReq;
    prev_rdy = imemReady;
    prev_addr = imemAddr;
  end

  task automatic push_op(input logic [2:0] op, input logic [31:0] wd);
    op_q.push_back(op);
    wd_q.push_back(wd);
  endtask

  task automatic release_reset();
    req_log.delete();
    exp_q.push_back(RESET_PC);
    fresh = 1'b1;
    reset = 1'b1;
  endtask

  task automatic assert_reset();
    reset = 1'b0;
    exp_q.delete();
    op_q.delete();
    wd_q.delete();
    fresh = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((op_q.size() != 0 || exp_q.size() != 0 || !instrValid) && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    check({tag, "_timeout"}, 32'(n < 300), 32'd1);
  endtask

  initial begin
    int k, i4;
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", 32'(instrValid), 32'd0);
    check("rst_req", 32'(imemReq), 32'd0);
    check("rst_instr", instr, NOP);
    check("rst_pc", pcReadData, RESET_PC);

    lat = 2;
    release_reset();
    k = 0;
    do begin
      @(negedge clk); #1;
      k++;
      if (k == 1) begin
        check("first_req", 32'(imemReq), 32'd1);
        check("first_addr", imemAddr, RESET_PC);
      end
    end while (!instrValid && k < 20);
    check("first_valid_cycle", 32'(k), 32'd4);
    drain("first");

    lat = 1;
    push_op(3'b000, 0);
    push_op(3'b101, 0);
    push_op(3'b000, 0);
    drain("straight");

    assert_reset();
    @(negedge clk); #1;
    lat = 3;
    release_reset();
    push_op(3'b001, 0);
    push_op(3'b010, 32'h0000_0103);
    repeat (5) push_op(3'b001, 0);
    push_op(3'b000, 0);
    drain("redirect_hold");
    i4 = -1;
    foreach (req_log[i]) if (i4 < 0 && req_log[i] == 32'h4) i4 = i;
    check("drop_stale_seen", 32'(i4 >= 0), 32'd1);
    check("drop_next_exists", 32'(i4 + 1 < req_log.size()), 32'd1);
    if (i4 >= 0 && i4 + 1 < req_log.size()) check("drop_next_addr", req_log[i4+1], 32'h100);
    check("hold_one_prefetch", 32'(log_at_consume - i4 - 2), 32'd1);
    check("zero_bubble", 32'(pop_cyc - consume_cyc), 32'd1);

    lat = 1;
    push_op(3'b010, 32'hFFFF_FFFF);
    push_op(3'b000, 0);
    push_op(3'b000, 0);
    drain("wrap");

    lat = 2;
    assert_reset();
    @(negedge clk); #1;
    release_reset();
    @(negedge clk); #1;
    check("mid_wait_req", 32'(imemReq), 32'd1);
    assert_reset();
    #1;
    check("mid_rst_valid", 32'(instrValid), 32'd0);
    check("mid_rst_req", 32'(imemReq), 32'd0);
    @(negedge clk); #1;
    force_rdy = 1'b1;
    @(negedge clk); #1;
    check("late_rdy_valid", 32'(instrValid), 32'd0);
    check("late_rdy_instr", instr, NOP);
    check("late_rdy_pc", pcReadData, RESET_PC);
    check("late_rdy_req", 32'(imemReq), 32'd0);
    force_rdy = 1'b0;
    release_reset();
    drain("restart");
    check("restart_logged", 32'(req_log.size() != 0), 32'd1);
    if (req_log.size() != 0) check("restart_addr", req_log[0], RESET_PC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
